reg_dump: RTL and testbench

Debug read-out engine for the single-cycle CPU (`sccomp`) register-probe port. On a start pulse it drives `reg_sel` through registers 0..31 and captures each `reg_data` word. It streams the words MSB-first as bytes over a valid/ready byte interface, framed by a header byte and trailed by an XOR checksum. It sits beside `sccomp` in the board top and feeds a UART TX or capture FIFO.

---
 rtl/reg_dump_pkg.sv | 28 ++
 rtl/reg_dump_if.sv | 15 +
 rtl/reg_dump_word_serializer.sv | 38 +++
 rtl/reg_dump.sv | 105 ++++++++++
 tb/tb_reg_dump.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/reg_dump_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_dump_pkg                                                               |
// | Shared constants, state encodings and helpers for the register dump engine |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package reg_dump_pkg;

   typedef logic [2:0] state_t;

   localparam int         c_NREGS          = 32;
   localparam int         c_SEL_W          = 5;
   localparam logic [7:0] c_HDR_BYTE       = 8'hA5;
   localparam int         c_BYTES_PER_WORD = 4;

   localparam state_t c_ST_IDLE = 3'd0;
   localparam state_t c_ST_HDR  = 3'd1;
   localparam state_t c_ST_SEL  = 3'd2;
   localparam state_t c_ST_SEND = 3'd3;
   localparam state_t c_ST_SUM  = 3'd4;
   localparam state_t c_ST_DONE = 3'd5;

   function automatic logic [7:0] msb_byte(input logic [31:0] i_word);
      return i_word[31:24];
   endfunction

endpackage
`default_nettype wire

// File: rtl/reg_dump_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_dump_if                                                                |
// | Valid/ready byte stream from the dump engine to its sink                   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface reg_dump_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/reg_dump_word_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_dump_word_serializer                                                   |
// | Holds one captured 32-bit word and presents it MSB-first a byte at a time  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module reg_dump_word_serializer
   import reg_dump_pkg::*;
(
   input  wire logic        clk,
   input  wire logic        rstn,
   input  wire logic        i_load,
   input  wire logic [31:0] i_word,
   input  wire logic        i_adv,
   output logic      [7:0]  o_byte,
   output logic             o_last
);
   logic [31:0] r_shift;
   logic [2:0]  r_bcnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_shift <= '0;
         r_bcnt  <= '0;
      end else if (i_load) begin
         r_shift <= i_word;
         r_bcnt  <= '0;
      end else if (i_adv) begin
         r_shift <= {r_shift[23:0], 8'h00};
         r_bcnt  <= r_bcnt + 3'd1;
      end
   end

   assign o_byte = msb_byte(r_shift);
   assign o_last = (r_bcnt == 3'(c_BYTES_PER_WORD - 1));

endmodule
`default_nettype wire

// File: rtl/reg_dump.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_dump                                                                   |
// | Walks reg_sel over the register file and streams header, words, checksum   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module reg_dump
   import reg_dump_pkg::*;
#(
   parameter int         NREGS    = c_NREGS,
   parameter int         SEL_W    = c_SEL_W,
   parameter logic [7:0] HDR_BYTE = c_HDR_BYTE
) (
   input  wire logic             clk,
   input  wire logic             rstn,
   input  wire logic             start,
   output logic                  busy,
   output logic                  done,
   output logic      [SEL_W-1:0] reg_sel,
   input  wire logic [31:0]      reg_data,
   reg_dump_if.master            tx
);
   state_t           r_state;
   state_t           w_next;
   logic [SEL_W-1:0] r_idx;
   logic [SEL_W-1:0] r_reg_sel;
   logic [7:0]       r_csum;
   logic [7:0]       w_byte;
   logic             w_last_byte;
   logic             w_last_reg;
   logic             w_xfer;
   logic             w_adv;
   logic             w_tx_valid;
   logic [7:0]       w_tx_data;

   assign w_xfer     = w_tx_valid && tx.tx_ready;
   assign w_adv      = (r_state == c_ST_SEND) && w_xfer;
   assign w_last_reg = (r_idx == SEL_W'(NREGS - 1));

   reg_dump_word_serializer u_ser (
      .clk    (clk),
      .rstn   (rstn),
      .i_load (r_state == c_ST_SEL),
      .i_word (reg_data),
      .i_adv  (w_adv),
      .o_byte (w_byte),
      .o_last (w_last_byte)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= c_ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_ST_IDLE: if (start)  w_next = c_ST_HDR;
         c_ST_HDR:  if (w_xfer) w_next = c_ST_SEL;
         c_ST_SEL:              w_next = c_ST_SEND;
         c_ST_SEND: if (w_adv && w_last_byte) w_next = w_last_reg ? c_ST_SUM : c_ST_SEL;
         c_ST_SUM:  if (w_xfer) w_next = c_ST_DONE;
         c_ST_DONE:             w_next = c_ST_IDLE;
         default:               w_next = c_ST_IDLE;
      endcase
   end

   // Outputs decode from registered state only, so tx_valid never follows tx_ready.
   always_comb begin
      w_tx_valid = 1'b0;
      w_tx_data  = 8'h00;
      busy       = (r_state != c_ST_IDLE);
      done       = (r_state == c_ST_DONE);
      case (r_state)
         c_ST_HDR:  begin w_tx_valid = 1'b1; w_tx_data = HDR_BYTE; end
         c_ST_SEND: begin w_tx_valid = 1'b1; w_tx_data = w_byte;   end
         c_ST_SUM:  begin w_tx_valid = 1'b1; w_tx_data = r_csum;   end
         default:   ;
      endcase
   end

   assign tx.tx_valid = w_tx_valid;
   assign tx.tx_data  = w_tx_data;
   assign reg_sel     = r_reg_sel;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_idx     <= '0;
         r_reg_sel <= '0;
         r_csum    <= '0;
      end else if (r_state == c_ST_IDLE) begin
         r_idx     <= '0;
         r_reg_sel <= '0;
         r_csum    <= '0;
      end else if (w_adv) begin
         r_csum <= r_csum ^ w_byte;
         if (w_last_byte && !w_last_reg) begin
            r_idx     <= r_idx + 1'b1;
            r_reg_sel <= r_idx + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_reg_dump.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_reg_dump                                                                |
// | Random-stimulus scoreboard bench for the register dump engine              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_reg_dump;
   logic        clk = 1'b0;
   logic        rstn;
   logic        start;
   logic        busy;
   logic        done;
   logic [4:0]  reg_sel;
   logic [31:0] reg_data;
   logic [31:0] regs [32];

   logic [7:0]  exp_q [$];
   logic [7:0]  got   [$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          done_cyc;
   logic        pend = 1'b0;
   logic [7:0]  pend_data = 8'h00;

   reg_dump_if u_if ();

   reg_dump u_dut (
      .clk      (clk),
      .rstn     (rstn),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .reg_sel  (reg_sel),
      .reg_data (reg_data),
      .tx       (u_if)
   );

   assign reg_data = regs[reg_sel];

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic fail(input string name);
      n_checks++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // Scoreboard monitor: every transfer pops the next expected byte.
   always @(negedge clk) begin
      if (!rstn) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            check("hold_valid", {31'd0, u_if.tx_valid}, 32'd1);
            check("hold_data", {24'd0, u_if.tx_data}, {24'd0, pend_data});
         end
         if (u_if.tx_valid && u_if.tx_ready) begin
            if (exp_q.size() == 0) fail("unexpected_byte");
            else check("stream_byte", {24'd0, u_if.tx_data}, {24'd0, exp_q.pop_front()});
            got.push_back(u_if.tx_data);
         end
         pend      = u_if.tx_valid && !u_if.tx_ready;
         pend_data = u_if.tx_data;
      end
   end

   task automatic check_outputs_zero(input string tag);
      check({tag, "_busy"},     {31'd0, busy},           32'd0);
      check({tag, "_done"},     {31'd0, done},           32'd0);
      check({tag, "_tx_valid"}, {31'd0, u_if.tx_valid},  32'd0);
      check({tag, "_tx_data"},  {24'd0, u_if.tx_data},   32'd0);
      check({tag, "_reg_sel"},  {27'd0, reg_sel},        32'd0);
   endtask

   task automatic check_idle(input int ncyc);
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         check("idle_busy", {31'd0, busy}, 32'd0);
         check("idle_valid", {31'd0, u_if.tx_valid}, 32'd0);
      end
   endtask

   // Reference frame: header, each word MSB-first, then XOR of all data bytes.
   task automatic build_expected();
      logic [7:0] b;
      logic [7:0] sum;
      exp_q.delete();
      got.delete();
      sum = 8'h00;
      exp_q.push_back(8'hA5);
      for (int r = 0; r < 32; r++) begin
         for (int k = 0; k < 4; k++) begin
            b = regs[r][31 - 8*k -: 8];
            exp_q.push_back(b);
            sum = sum ^ b;
         end
      end
      exp_q.push_back(sum);
   endtask

   // mode 0: ready=1; 1: random ready + 10-cycle stall at reg 12 byte 2;
   // 2: stray start pulses in cycles 50 and 163; 3: reset during reg 20;
   // 4: reg 5 modified right after its capture.
   task automatic run_frame(input int mode, output int dcyc);
      int         nxfer;
      int         stall;
      bit         stalled;
      bit         sel5_seen;
      bit         chg;
      logic       xfer;
      logic [7:0] stall_byte;
      nxfer = 0; stall = 0; stalled = 0; sel5_seen = 0; chg = 0;
      dcyc = -1;
      build_expected();
      stall_byte = exp_q[51];
      @(posedge clk); #1;
      start = 1'b1;
      u_if.tx_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 3000; c++) begin
         @(negedge clk);
         xfer = u_if.tx_valid && u_if.tx_ready;
         if (c == 1) begin
            check("hdr_valid", {31'd0, u_if.tx_valid}, 32'd1);
            check("hdr_data", {24'd0, u_if.tx_data}, 32'hA5);
            check("hdr_done_low", {31'd0, done}, 32'd0);
         end
         check("busy_in_frame", {31'd0, busy}, 32'd1);
         if (stall > 0) begin
            check("stall_valid", {31'd0, u_if.tx_valid}, 32'd1);
            check("stall_data", {24'd0, u_if.tx_data}, {24'd0, stall_byte});
            check("stall_reg_sel", {27'd0, reg_sel}, 32'd12);
         end
         if (mode == 4 && nxfer == 21 && !sel5_seen) begin
            check("sel5_reg_sel", {27'd0, reg_sel}, 32'd5);
            check("sel5_valid", {31'd0, u_if.tx_valid}, 32'd0);
            sel5_seen = 1; chg = 1;
         end
         if (done) begin
            dcyc = c;
            check("frame_bytes", got.size(), 32'd130);
            return;
         end
         @(posedge clk);
         if (xfer) nxfer++;
         #1;
         start = (mode == 2 && (c + 1 == 50 || c + 1 == 163));
         if (chg) begin
            regs[5] = regs[5] ^ 32'hFFFF_0F0F;
            chg = 0;
         end
         if (mode == 3 && nxfer == 82) begin
            rstn  = 1'b0;
            start = 1'($urandom_range(0, 1));
            u_if.tx_ready = 1'($urandom_range(0, 1));
            #1;
            check_outputs_zero("midreset");
            exp_q.delete();
            @(posedge clk); #1;
            rstn = 1'b1; start = 1'b0; u_if.tx_ready = 1'b1;
            dcyc = -2;
            return;
         end
         if (mode == 1) begin
            if (stall > 0) stall--;
            if (!stalled && nxfer == 51) begin stall = 10; stalled = 1; end
            u_if.tx_ready = (stall > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
         end else begin
            u_if.tx_ready = 1'b1;
         end
      end
      fail("frame_timeout");
   endtask

   task automatic randomize_regs();
      for (int r = 0; r < 32; r++) regs[r] = $urandom;
   endtask

   initial begin
      rstn = 1'b0; start = 1'b0; u_if.tx_ready = 1'b0;
      for (int r = 0; r < 32; r++) regs[r] = 32'd0;
      regs[7] = 32'hDEADBEEF;
      repeat (2) @(negedge clk);
      check_outputs_zero("reset");
      @(posedge clk); #1 rstn = 1'b1;
      check_idle(3);

      // Known pattern, then a chained frame started in the cycle after DONE.
      run_frame(0, done_cyc);
      check("done_cycle_a", done_cyc, 32'd163);
      check("byte0", {24'd0, got[0]}, 32'hA5);
      check("byte29", {24'd0, got[29]}, 32'hDE);
      check("byte30", {24'd0, got[30]}, 32'hAD);
      check("byte31", {24'd0, got[31]}, 32'hBE);
      check("byte32", {24'd0, got[32]}, 32'hEF);
      check("checksum", {24'd0, got[129]}, 32'h22);
      run_frame(0, done_cyc);
      check("done_cycle_chained", done_cyc, 32'd163);

      randomize_regs();
      run_frame(1, done_cyc);
      check("bp_frame_done", {31'd0, done_cyc > 163}, 32'd1);

      randomize_regs();
      run_frame(2, done_cyc);
      check("done_cycle_stray_start", done_cyc, 32'd163);
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      check("after_done_busy", {31'd0, busy}, 32'd0);
      check("after_done_done", {31'd0, done}, 32'd0);

      randomize_regs();
      run_frame(3, done_cyc);
      check("reset_abort", done_cyc, 32'hFFFF_FFFE);
      check_idle(2);
      run_frame(0, done_cyc);
      check("done_cycle_after_reset", done_cyc, 32'd163);

      randomize_regs();
      run_frame(4, done_cyc);
      check("done_cycle_isolation", done_cyc, 32'd163);

      check_idle(2);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
